// File: rtl/present_sbox_dom_layer.sv
// NSBOX parallel PRESENT S-boxes, first-order 2-share DOM masking.
// Three register stages: level-1 DOM-ANDs, level-2 DOM-ANDs, output linear layer.
module present_sbox_dom_layer #(
  parameter int NSBOX = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  input  logic [4*NSBOX-1:0] x_s0,
  input  logic [4*NSBOX-1:0] x_s1,
  input  logic [4*NSBOX-1:0] rnd,
  output logic               out_valid,
  output logic [4*NSBOX-1:0] y_s0,
  output logic [4*NSBOX-1:0] y_s1,
  output logic               busy
);

  // Decomposition: p = x1&x2, q = x3&(x1^x2), r = (x0^x1)&(p^x1^x3),
  // s = (x0^x3)&(q^x0^x1); the affine constant c is carried by share 0 only.
  function automatic logic [3:0] out_layer(input logic [3:0] x, input logic p, input logic q,
                                           input logic r, input logic s, input logic c);
    logic [3:0] y;
    y[0] = x[0] ^ x[2] ^ x[3] ^ p;
    y[1] = r ^ s ^ p ^ x[0] ^ x[3];
    y[2] = s ^ q ^ x[0] ^ x[2] ^ x[3] ^ c;
    y[3] = r ^ s ^ q ^ x[3] ^ c;
    return y;
  endfunction

  logic vld_p1, vld_p2, vld_p3;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else if (en) begin
      vld_p1 <= in_valid;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  assign out_valid = vld_p3;
  assign busy      = vld_p1 | vld_p2 | vld_p3;

  for (genvar k = 0; k < NSBOX; k++) begin : g_sbox
    logic [3:0] a, b;
    logic [3:0] a_p1, b_p1, a_p2, b_p2;
    logic       pi0_p1, pc0_p1, pi1_p1, pc1_p1;
    logic       qi0_p1, qc0_p1, qi1_p1, qc1_p1;
    logic [1:0] rh_p1;
    logic       p0, p1, q0, q1;
    logic       ra0, rb0, ra1, rb1, sa0, sb0, sa1, sb1;
    logic       p0_p2, p1_p2, q0_p2, q1_p2;
    logic       ri0_p2, rc0_p2, ri1_p2, rc1_p2;
    logic       si0_p2, sc0_p2, si1_p2, sc1_p2;
    logic [3:0] y0_p3, y1_p3;

    assign a = x_s0[4*k +: 4];
    assign b = x_s1[4*k +: 4];

    // Stage 0 -> 1: level-1 DOM-ANDs, cross terms masked before the register
    always_ff @(posedge clk) begin
      if (rst) begin
        a_p1   <= '0;
        b_p1   <= '0;
        pi0_p1 <= 1'b0;
        pc0_p1 <= 1'b0;
        pi1_p1 <= 1'b0;
        pc1_p1 <= 1'b0;
        qi0_p1 <= 1'b0;
        qc0_p1 <= 1'b0;
        qi1_p1 <= 1'b0;
        qc1_p1 <= 1'b0;
        rh_p1  <= '0;
      end else if (en) begin
        a_p1   <= a;
        b_p1   <= b;
        pi0_p1 <= a[1] & a[2];
        pc0_p1 <= (a[1] & b[2]) ^ rnd[4*k];
        pi1_p1 <= b[1] & b[2];
        pc1_p1 <= (b[1] & a[2]) ^ rnd[4*k];
        qi0_p1 <= a[3] & (a[1] ^ a[2]);
        qc0_p1 <= (a[3] & (b[1] ^ b[2])) ^ rnd[4*k+1];
        qi1_p1 <= b[3] & (b[1] ^ b[2]);
        qc1_p1 <= (b[3] & (a[1] ^ a[2])) ^ rnd[4*k+1];
        rh_p1  <= rnd[4*k+2 +: 2];
      end
    end

    assign p0  = pi0_p1 ^ pc0_p1;
    assign p1  = pi1_p1 ^ pc1_p1;
    assign q0  = qi0_p1 ^ qc0_p1;
    assign q1  = qi1_p1 ^ qc1_p1;
    assign ra0 = a_p1[0] ^ a_p1[1];
    assign rb0 = p0 ^ a_p1[1] ^ a_p1[3];
    assign ra1 = b_p1[0] ^ b_p1[1];
    assign rb1 = p1 ^ b_p1[1] ^ b_p1[3];
    assign sa0 = a_p1[0] ^ a_p1[3];
    assign sb0 = q0 ^ a_p1[0] ^ a_p1[1];
    assign sa1 = b_p1[0] ^ b_p1[3];
    assign sb1 = q1 ^ b_p1[0] ^ b_p1[1];

    // Stage 1 -> 2: level-2 DOM-ANDs; x, p and q shares delayed per share
    always_ff @(posedge clk) begin
      if (rst) begin
        a_p2   <= '0;
        b_p2   <= '0;
        p0_p2  <= 1'b0;
        p1_p2  <= 1'b0;
        q0_p2  <= 1'b0;
        q1_p2  <= 1'b0;
        ri0_p2 <= 1'b0;
        rc0_p2 <= 1'b0;
        ri1_p2 <= 1'b0;
        rc1_p2 <= 1'b0;
        si0_p2 <= 1'b0;
        sc0_p2 <= 1'b0;
        si1_p2 <= 1'b0;
        sc1_p2 <= 1'b0;
      end else if (en) begin
        a_p2   <= a_p1;
        b_p2   <= b_p1;
        p0_p2  <= p0;
        p1_p2  <= p1;
        q0_p2  <= q0;
        q1_p2  <= q1;
        ri0_p2 <= ra0 & rb0;
        rc0_p2 <= (ra0 & rb1) ^ rh_p1[0];
        ri1_p2 <= ra1 & rb1;
        rc1_p2 <= (ra1 & rb0) ^ rh_p1[0];
        si0_p2 <= sa0 & sb0;
        sc0_p2 <= (sa0 & sb1) ^ rh_p1[1];
        si1_p2 <= sa1 & sb1;
        sc1_p2 <= (sa1 & sb0) ^ rh_p1[1];
      end
    end

    // Stage 2 -> 3: recombine level-2 shares and apply the output affine layer
    always_ff @(posedge clk) begin
      if (rst) begin
        y0_p3 <= '0;
        y1_p3 <= '0;
      end else if (en) begin
        y0_p3 <= out_layer(a_p2, p0_p2, q0_p2, ri0_p2 ^ rc0_p2, si0_p2 ^ sc0_p2, 1'b1);
        y1_p3 <= out_layer(b_p2, p1_p2, q1_p2, ri1_p2 ^ rc1_p2, si1_p2 ^ sc1_p2, 1'b0);
      end
    end

    assign y_s0[4*k +: 4] = y0_p3;
    assign y_s1[4*k +: 4] = y1_p3;
  end

endmodule

// File: tb/tb_present_sbox_dom_layer.sv
// Scoreboard bench for present_sbox_dom_layer (NSBOX=16 main instance, NSBOX=1 corner).
module tb_present_sbox_dom_layer;
  localparam int N = 16;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst, en, in_valid;
  logic [W-1:0] x_s0, x_s1, rnd, y_s0, y_s1;
  logic         out_valid, busy;
  logic         v1_in, v1_out, v1_busy;
  logic [3:0]   c_s0, c_s1, c_rnd, d_s0, d_s1;

  present_sbox_dom_layer #(.NSBOX(N)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .x_s0(x_s0), .x_s1(x_s1), .rnd(rnd),
    .out_valid(out_valid), .y_s0(y_s0), .y_s1(y_s1), .busy(busy)
  );

  present_sbox_dom_layer #(.NSBOX(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .in_valid(v1_in),
    .x_s0(c_s0), .x_s1(c_s1), .rnd(c_rnd),
    .out_valid(v1_out), .y_s0(d_s0), .y_s1(d_s1), .busy(v1_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         vld;
    logic [W-1:0] y;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [3:0] s4(input logic [3:0] v);
    case (v)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  function automatic logic [W-1:0] s_layer(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) r[4*i +: 4] = s4(x[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_w();
    return {$urandom(), $urandom()};
  endfunction

  // Advances one clock and updates the timing model: 3 enabled edges of latency.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    if (rst) begin
      sb.delete();
      sb.push_back('0);
      sb.push_back('0);
      last = '0;
    end else if (en) begin
      e.vld = in_valid;
      e.y   = s_layer(x_s0 ^ x_s1);
      sb.push_back(e);
      last = sb.pop_front();
    end
    #1;
  endtask

  function automatic logic exp_busy();
    return last.vld | sb[0].vld | sb[1].vld;
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; in_valid = 1'b1; v1_in = 1'b1;
    x_s0 = rand_w(); x_s1 = rand_w(); rnd = rand_w();
    c_s0 = 4'h3; c_s1 = 4'h5; c_rnd = 4'h0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: out_valid=%b busy=%b want 0 0", out_valid, busy);
    end
    checks++;
    if (y_s0 !== '0 || y_s1 !== '0) begin
      failures++;
      $display("FAIL reset_data: y_s0=%h y_s1=%h want 0 0", y_s0, y_s1);
    end
    checks++;
    if (v1_out !== 1'b0 || v1_busy !== 1'b0 || d_s0 !== 4'h0 || d_s1 !== 4'h0) begin
      failures++;
      $display("FAIL reset_n1: out_valid=%b busy=%b y=%h/%h want 0", v1_out, v1_busy, d_s0, d_s1);
    end
    rst = 1'b0; en = 1'b1; in_valid = 1'b0; v1_in = 1'b0;
  endtask

  task automatic test_unmasked();
    int pulses = 0;
    x_s0 = 64'hFEDCBA9876543210; x_s1 = '0; rnd = '0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick();
      pulses += int'(out_valid);
      checks++;
      if (out_valid !== last.vld || busy !== exp_busy()) begin
        failures++;
        $display("FAIL unmasked_vld c%0d: vld=%b busy=%b want %b %b", c, out_valid, busy, last.vld, exp_busy());
      end
      if (last.vld) begin
        checks++;
        if ((y_s0 ^ y_s1) !== last.y) begin
          failures++;
          $display("FAIL unmasked_y: got %h want %h", y_s0 ^ y_s1, last.y);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL unmasked_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n + 3; i++) begin
      in_valid = (i < n);
      x_s0 = rand_w(); x_s1 = rand_w(); rnd = rand_w();
      tick();
      checks++;
      if (out_valid !== last.vld || busy !== exp_busy()) begin
        failures++;
        $display("FAIL random_vld i%0d: vld=%b busy=%b want %b %b", i, out_valid, busy, last.vld, exp_busy());
      end
      if (last.vld) begin
        checks++;
        if ((y_s0 ^ y_s1) !== last.y) begin
          failures++;
          $display("FAIL random_y i%0d: got %h want %h", i, y_s0 ^ y_s1, last.y);
        end
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 12; i++) begin
      en       = !(i >= 3 && i < 8);
      in_valid = (i < 8);
      x_s0 = rand_w(); x_s1 = rand_w(); rnd = rand_w();
      tick();
      checks++;
      if (out_valid !== last.vld || busy !== exp_busy()) begin
        failures++;
        $display("FAIL stall_vld i%0d: vld=%b busy=%b want %b %b", i, out_valid, busy, last.vld, exp_busy());
      end
      if (last.vld) begin
        checks++;
        if ((y_s0 ^ y_s1) !== last.y) begin
          failures++;
          $display("FAIL stall_y i%0d: got %h want %h", i, y_s0 ^ y_s1, last.y);
        end
      end
    end
    en = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; x_s0 = rand_w(); x_s1 = rand_w(); rnd = rand_w();
      tick();
    end
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || y_s0 !== '0 || y_s1 !== '0) begin
      failures++;
      $display("FAIL midreset: vld=%b busy=%b y=%h/%h want all 0", out_valid, busy, y_s0, y_s1);
    end
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== exp_busy()) begin
        failures++;
        $display("FAIL midreset_stale i%0d: vld=%b busy=%b want 0 %b", i, out_valid, busy, exp_busy());
      end
    end
  endtask

  task automatic test_rnd_indep();
    logic [W-1:0] m;
    m = rand_w();
    for (int i = 0; i < W + 3; i++) begin
      in_valid = (i < W);
      x_s1 = m;
      x_s0 = m ^ 64'h1111111111111111;
      rnd  = (i < W) ? (64'd1 << i) : '0;
      tick();
      checks++;
      if (out_valid !== last.vld) begin
        failures++;
        $display("FAIL rnd_vld i%0d: got %b want %b", i, out_valid, last.vld);
      end
      if (last.vld) begin
        checks++;
        if ((y_s0 ^ y_s1) !== last.y) begin
          failures++;
          $display("FAIL rnd_y i%0d: got %h want %h", i, y_s0 ^ y_s1, last.y);
        end
      end
    end
  endtask

  task automatic test_nsbox1();
    c_s1 = 4'($urandom_range(0, 15));
    c_s0 = 4'hA ^ c_s1;
    c_rnd = 4'($urandom_range(0, 15));
    v1_in = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      v1_in = 1'b0;
      c_s0 = 4'($urandom_range(0, 15));
      checks++;
      if (v1_out !== (c == 3)) begin
        failures++;
        $display("FAIL n1_vld c%0d: got %b want %b", c, v1_out, (c == 3));
      end
      if (c == 3) begin
        checks++;
        if ((d_s0 ^ d_s1) !== 4'hF) begin
          failures++;
          $display("FAIL n1_y: got %h want f", d_s0 ^ d_s1);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; in_valid = 1'b0; v1_in = 1'b0;
    x_s0 = '0; x_s1 = '0; rnd = '0;
    c_s0 = '0; c_s1 = '0; c_rnd = '0;
    test_reset();
    test_unmasked();
    test_random(2000);
    test_stall();
    test_reset_midflight();
    test_rnd_indep();
    test_nsbox1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
